// File: rtl/ex_mem_reg_if.sv
// Execute-stage result bundle: GPR write address/enable/data and the HI/LO write triple.
// The producer side uses the master modport and the consumer side uses the slave modport.
interface ex_mem_reg_if #(
    parameter int REG_W  = 32,
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] wd;
    logic              wreg;
    logic [REG_W-1:0]  wdata;
    logic [REG_W-1:0]  hi;
    logic [REG_W-1:0]  lo;
    logic              whilo;

    modport master (output wd, wreg, wdata, hi, lo, whilo);
    modport slave  (input  wd, wreg, wdata, hi, lo, whilo);
endinterface

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register: inserts bubbles on stall, clears on flush, and carries the
// madd/msub partial accumulator back to execute across stalls. It also keeps a saturating bubble count.
module ex_mem_reg #(
    parameter int REG_W   = 32,
    parameter int ADDR_W  = 5,
    parameter int STALL_W = 6,
    parameter int EX_BIT  = 3,
    parameter int MEM_BIT = 4,
    parameter int BCNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [STALL_W-1:0]   stall,
    input  logic                 flush,
    ex_mem_reg_if.slave          ex_if,
    ex_mem_reg_if.master         mem_if,
    input  logic [2*REG_W-1:0]   hilo_i,
    input  logic [1:0]           cnt_i,
    output logic                 mem_valid,
    output logic [2*REG_W-1:0]   hilo_o,
    output logic [1:0]           cnt_o,
    output logic [BCNT_W-1:0]    bubble_cnt
);

    logic es, ms;
    logic stall_unused;

    assign es = stall[EX_BIT];
    assign ms = stall[MEM_BIT];
    // Only the execute and memory bits matter here. The rest of the vector is reduced away.
    assign stall_unused = ^stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_if.wd    <= '0;
            mem_if.wreg  <= 1'b0;
            mem_if.wdata <= '0;
            mem_if.hi    <= '0;
            mem_if.lo    <= '0;
            mem_if.whilo <= 1'b0;
            mem_valid    <= 1'b0;
            hilo_o       <= '0;
            cnt_o        <= '0;
            bubble_cnt   <= '0;
        end else if (flush) begin
            mem_if.wd    <= '0;
            mem_if.wreg  <= 1'b0;
            mem_if.wdata <= '0;
            mem_if.hi    <= '0;
            mem_if.lo    <= '0;
            mem_if.whilo <= 1'b0;
            mem_valid    <= 1'b0;
            hilo_o       <= '0;
            cnt_o        <= '0;
        end else if (!es && !ms) begin
            mem_if.wd    <= ex_if.wd;
            mem_if.wreg  <= ex_if.wreg;
            mem_if.wdata <= ex_if.wdata;
            mem_if.hi    <= ex_if.hi;
            mem_if.lo    <= ex_if.lo;
            mem_if.whilo <= ex_if.whilo;
            mem_valid    <= 1'b1;
            hilo_o       <= '0;
            cnt_o        <= '0;
        end else if (es && !ms) begin
            // The bubble drops both write enables, and the partial madd/msub state is parked for execute.
            mem_if.wd    <= '0;
            mem_if.wreg  <= 1'b0;
            mem_if.wdata <= '0;
            mem_if.hi    <= '0;
            mem_if.lo    <= '0;
            mem_if.whilo <= 1'b0;
            mem_valid    <= 1'b0;
            hilo_o       <= hilo_i;
            cnt_o        <= cnt_i;
            if (bubble_cnt != {BCNT_W{1'b1}})
                bubble_cnt <= bubble_cnt + 1'b1;
        end
        // Both stalled, or the illegal ms-without-es case: every output holds its value.
    end

    illegal_stall_a: assert property (@(posedge clk) disable iff (rst || flush) !(ms && !es))
        else $warning("ex_mem_reg: memory stalled while execute advances; holding");

endmodule

// File: tb/tb_ex_mem_reg.sv
// Scoreboard bench for ex_mem_reg. A reference model pushes the expected output set for each edge,
// and each test task pops that set and compares it with the outputs sampled 1 time unit after the edge.
module tb_ex_mem_reg;

    typedef struct packed {
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        whilo;
        logic        valid;
        logic [63:0] hilo;
        logic [1:0]  cnt;
        logic [15:0] bcnt;
    } out_t;

    logic        clk;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic [63:0] hilo_i;
    logic [1:0]  cnt_i;
    logic        mem_valid;
    logic [63:0] hilo_o;
    logic [1:0]  cnt_o;
    logic [15:0] bubble_cnt;

    ex_mem_reg_if #(.REG_W(32), .ADDR_W(5)) ex_if ();
    ex_mem_reg_if #(.REG_W(32), .ADDR_W(5)) mem_if ();

    ex_mem_reg dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .flush      (flush),
        .ex_if      (ex_if),
        .mem_if     (mem_if),
        .hilo_i     (hilo_i),
        .cnt_i      (cnt_i),
        .mem_valid  (mem_valid),
        .hilo_o     (hilo_o),
        .cnt_o      (cnt_o),
        .bubble_cnt (bubble_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    out_t m;
    out_t sb[$];
    int   vectors = 0;
    int   errors  = 0;

    function automatic out_t observe();
        out_t o;
        o.wd = mem_if.wd; o.wreg = mem_if.wreg; o.wdata = mem_if.wdata;
        o.hi = mem_if.hi; o.lo = mem_if.lo; o.whilo = mem_if.whilo;
        o.valid = mem_valid; o.hilo = hilo_o; o.cnt = cnt_o; o.bcnt = bubble_cnt;
        return o;
    endfunction

    // Computes the expected result of the coming edge from the current inputs, queues it, and then takes the edge.
    task automatic step();
        out_t e;
        logic es, ms;
        es = stall[3];
        ms = stall[4];
        e = m;
        if (rst) begin
            e = '0;
        end else if (flush) begin
            e = '0;
            e.bcnt = m.bcnt;
        end else if (!es && !ms) begin
            e.wd = ex_if.wd; e.wreg = ex_if.wreg; e.wdata = ex_if.wdata;
            e.hi = ex_if.hi; e.lo = ex_if.lo; e.whilo = ex_if.whilo;
            e.valid = 1'b1; e.hilo = '0; e.cnt = '0;
        end else if (es && !ms) begin
            e = '0;
            e.hilo = hilo_i;
            e.cnt = cnt_i;
            e.bcnt = (m.bcnt == 16'hFFFF) ? m.bcnt : m.bcnt + 16'd1;
        end
        m = e;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic set_ex(input logic [4:0] wd, input logic wreg, input logic [31:0] wdata,
                          input logic [31:0] hi, input logic [31:0] lo, input logic whilo);
        ex_if.wd = wd; ex_if.wreg = wreg; ex_if.wdata = wdata;
        ex_if.hi = hi; ex_if.lo = lo; ex_if.whilo = whilo;
    endtask

    task automatic test_reset();
        out_t got, exp;
        rst = 1'b1; flush = 1'b0; stall = 6'b001000;
        hilo_i = 64'hFFFF_0000_FFFF_0000; cnt_i = 2'd3;
        set_ex(5'd31, 1'b1, 32'hDEADBEEF, 32'h1111_2222, 32'h3333_4444, 1'b1);
        for (int i = 0; i < 2; i++) begin
            step();
            got = observe(); exp = sb.pop_front(); vectors++;
            if (got !== exp) begin errors++; $display("FAIL reset got=%h exp=%h", got, exp); end
        end
        vectors++;
        if (got !== '0) begin errors++; $display("FAIL reset_zero got=%h exp=0", got); end
        rst = 1'b0; stall = 6'b000000;
        step();
        got = observe(); exp = sb.pop_front(); vectors++;
        if (got !== exp) begin errors++; $display("FAIL reset_release got=%h exp=%h", got, exp); end
        vectors++;
        if (mem_if.wdata !== 32'hDEADBEEF || mem_valid !== 1'b1) begin
            errors++; $display("FAIL release_data got=%h/%b exp=deadbeef/1", mem_if.wdata, mem_valid);
        end
    endtask

    task automatic test_bubble();
        out_t got, exp;
        stall = 6'b001000; hilo_i = 64'h0000_0001_0000_0002; cnt_i = 2'd1;
        set_ex(5'd9, 1'b1, 32'hCAFE_0001, 32'h5, 32'h6, 1'b1);
        step();
        got = observe(); exp = sb.pop_front(); vectors++;
        if (got !== exp) begin errors++; $display("FAIL bubble got=%h exp=%h", got, exp); end
        vectors++;
        if (mem_if.wreg !== 1'b0 || mem_if.whilo !== 1'b0 || mem_valid !== 1'b0 ||
            hilo_o !== 64'h0000_0001_0000_0002 || cnt_o !== 2'd1 || bubble_cnt !== 16'd1) begin
            errors++; $display("FAIL bubble_lit got=%b%b%b %h %0d %0d exp=000 0000000100000002 1 1",
                               mem_if.wreg, mem_if.whilo, mem_valid, hilo_o, cnt_o, bubble_cnt);
        end
        stall = 6'b000000;
        step();
        got = observe(); exp = sb.pop_front(); vectors++;
        if (got !== exp) begin errors++; $display("FAIL bubble_resume got=%h exp=%h", got, exp); end
        vectors++;
        if (hilo_o !== 64'd0 || cnt_o !== 2'd0 || mem_if.wdata !== 32'hCAFE_0001) begin
            errors++; $display("FAIL resume_lit got=%h %0d %h exp=0 0 cafe0001", hilo_o, cnt_o, mem_if.wdata);
        end
    endtask

    task automatic test_hold();
        out_t got, exp;
        logic [15:0] b0;
        stall = 6'b000000;
        set_ex(5'd7, 1'b1, 32'h1234, 32'h0, 32'h0, 1'b0);
        step();
        got = observe(); exp = sb.pop_front(); vectors++;
        if (got !== exp) begin errors++; $display("FAIL hold_capture got=%h exp=%h", got, exp); end
        b0 = bubble_cnt;
        stall = 6'b011000;
        for (int i = 0; i < 3; i++) begin
            set_ex(5'd20 + 5'(i), 1'b0, 32'hABCD_0000 + i, 32'h9, 32'h8, 1'b1);
            hilo_i = 64'h55 + 64'(i);
            step();
            got = observe(); exp = sb.pop_front(); vectors++;
            if (got !== exp) begin errors++; $display("FAIL hold got=%h exp=%h", got, exp); end
            vectors++;
            if (mem_if.wd !== 5'd7 || mem_if.wdata !== 32'h1234 || bubble_cnt !== b0) begin
                errors++; $display("FAIL hold_lit got=%0d %h %0d exp=7 1234 %0d", mem_if.wd, mem_if.wdata, bubble_cnt, b0);
            end
        end
    endtask

    task automatic test_flush();
        out_t got, exp;
        logic [15:0] b0;
        stall = 6'b001000; hilo_i = 64'h0123_4567_89AB_CDEF; cnt_i = 2'd2;
        step();
        got = observe(); exp = sb.pop_front(); vectors++;
        if (got !== exp) begin errors++; $display("FAIL flush_pre got=%h exp=%h", got, exp); end
        b0 = bubble_cnt;
        flush = 1'b1;
        step();
        flush = 1'b0;
        got = observe(); exp = sb.pop_front(); vectors++;
        if (got !== exp) begin errors++; $display("FAIL flush got=%h exp=%h", got, exp); end
        vectors++;
        if (hilo_o !== 64'd0 || cnt_o !== 2'd0 || mem_valid !== 1'b0 || bubble_cnt !== b0) begin
            errors++; $display("FAIL flush_lit got=%h %0d %b %0d exp=0 0 0 %0d", hilo_o, cnt_o, mem_valid, bubble_cnt, b0);
        end
    endtask

    task automatic test_illegal_stall();
        out_t got, exp;
        stall = 6'b000000;
        set_ex(5'd12, 1'b1, 32'h7777_0001, 32'hAA, 32'hBB, 1'b1);
        step();
        got = observe(); exp = sb.pop_front(); vectors++;
        if (got !== exp) begin errors++; $display("FAIL illegal_pre got=%h exp=%h", got, exp); end
        stall = 6'b010000;
        set_ex(5'd1, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
        step();
        got = observe(); exp = sb.pop_front(); vectors++;
        if (got !== exp) begin errors++; $display("FAIL illegal got=%h exp=%h", got, exp); end
        vectors++;
        if (mem_if.wd !== 5'd12 || mem_if.wdata !== 32'h7777_0001 || mem_valid !== 1'b1) begin
            errors++; $display("FAIL illegal_lit got=%0d %h %b exp=12 77770001 1", mem_if.wd, mem_if.wdata, mem_valid);
        end
        stall = 6'b000000;
    endtask

    task automatic test_back_to_back();
        out_t got, exp;
        logic [1:0] mode;
        for (int i = 0; i < 200; i++) begin
            mode = 2'($urandom_range(0, 3));
            stall = 6'($urandom) & 6'b100111;
            case (mode)
                2'd1: stall[3] = 1'b1;
                2'd2: begin stall[3] = 1'b1; stall[4] = 1'b1; end
                default: ;
            endcase
            flush = ($urandom_range(0, 15) == 0);
            set_ex(5'($urandom), 1'($urandom), $urandom, $urandom, $urandom, 1'($urandom));
            hilo_i = {$urandom, $urandom}; cnt_i = 2'($urandom);
            step();
            got = observe(); exp = sb.pop_front(); vectors++;
            if (got !== exp) begin errors++; $display("FAIL back_to_back[%0d] got=%h exp=%h", i, got, exp); end
        end
        flush = 1'b0;
    endtask

    task automatic test_saturation();
        out_t got, exp;
        stall = 6'b001000; hilo_i = 64'h1; cnt_i = 2'd1;
        for (int i = 0; i < 65535 + 3; i++) begin
            step();
            got = observe(); exp = sb.pop_front(); vectors++;
            if (got !== exp) begin errors++; $display("FAIL saturation[%0d] got=%h exp=%h", i, got, exp); end
        end
        vectors++;
        if (bubble_cnt !== 16'hFFFF) begin errors++; $display("FAIL saturation_lit got=%h exp=ffff", bubble_cnt); end
        stall = 6'b000000;
    endtask

    initial begin
        m = '0;
        rst = 1'b1; flush = 1'b0; stall = '0; hilo_i = '0; cnt_i = '0;
        set_ex('0, 1'b0, '0, '0, '0, 1'b0);
        test_reset();
        test_bubble();
        test_hold();
        test_flush();
        test_illegal_stall();
        test_back_to_back();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/ex_mem_reg.md
Name: ex_mem_reg

Overview:
- Pipeline register between the execute stage and the memory-access stage of the 5-stage MIPS core.
- Receiving end of the execute-stage result interface: GPR write address, GPR write enable, GPR write data, and the HI/LO write triple.
- Inserts bubbles under stall control and clears on flush.
- Preserves the partial 64-bit accumulator and step count of multi-cycle HI/LO ops (madd/msub) across execute stalls, returning them to the execute stage.
- Keeps a saturating count of inserted bubbles for performance analysis.

Parameters:
REG_W, 32, width of GPR, HI and LO data
ADDR_W, 5, width of GPR write address
STALL_W, 6, width of the pipeline stall vector
EX_BIT, 3, index of the execute-stage bit in the stall vector
MEM_BIT, 4, index of the memory-stage bit in the stall vector
BCNT_W, 16, width of the bubble counter

Ports:
clk  in  1  core clock; all state updates on rising edge
rst  in  1  reset, synchronous, active-high
stall  in  STALL_W  per-stage stall request vector from the control unit
flush  in  1  pipeline flush (exception/eret); clears this stage
ex_wd  in  ADDR_W  GPR destination address from execute
ex_wreg  in  1  GPR write enable from execute
ex_wdata  in  REG_W  GPR write data from execute
ex_hi  in  REG_W  HI write value from execute
ex_lo  in  REG_W  LO write value from execute
ex_whilo  in  1  HI/LO write enable from execute
hilo_i  in  2*REG_W  partial accumulator from execute (multi-cycle op)
cnt_i  in  2  step count of the multi-cycle op from execute
mem_wd  out  ADDR_W  registered GPR destination to memory stage
mem_wreg  out  1  registered GPR write enable
mem_wdata  out  REG_W  registered GPR write data
mem_hi  out  REG_W  registered HI value
mem_lo  out  REG_W  registered LO value
mem_whilo  out  1  registered HI/LO write enable
mem_valid  out  1  1 = memory stage holds a real instruction, 0 = bubble
hilo_o  out  2*REG_W  held accumulator returned to execute
cnt_o  out  2  held step count returned to execute
bubble_cnt  out  BCNT_W  saturating count of bubbles inserted

Behaviour:
- Reset: when rst=1 at a clock edge, every output is 0, including bubble_cnt.
- Latency: 1 cycle. An input captured at edge N is visible from edge N until the next update.
- Priority per edge: rst > flush > stall decode > normal capture. Let es = stall[EX_BIT] and ms = stall[MEM_BIT].
- flush=1: all mem_* outputs 0, mem_valid 0, hilo_o 0, cnt_o 0. bubble_cnt unchanged. Flush overrides any stall value.
- es=0, ms=0 (advance):
  - mem_* <= ex_*, mem_valid <= 1.
  - hilo_o <= 0, cnt_o <= 0.
- es=1, ms=0 (bubble):
  - mem_wd, mem_wreg, mem_wdata, mem_hi, mem_lo, mem_whilo all <= 0; mem_valid <= 0.
  - hilo_o <= hilo_i, cnt_o <= cnt_i, so an in-progress madd/msub resumes with its partial sum.
  - bubble_cnt increments by 1, saturating at all-ones; it never wraps.
- es=1, ms=1 (hold): every output keeps its value, including hilo_o, cnt_o and bubble_cnt.
- es=0, ms=1: illegal (a stalled consumer with an advancing producer). Treat as hold (all outputs keep value). Simulation-only assertion fires.
- The bubble encoding guarantees no GPR or HI/LO write downstream: mem_wreg=0 and mem_whilo=0.
- hilo_o and cnt_o are fed back to execute combinationally. This block adds no path from ex_* to any output other than through a register.
- Reset mid multi-cycle op: accumulator and count return to 0; execute restarts the op.
- Stall bits other than EX_BIT and MEM_BIT are ignored.

Test Plan:
- Reset: rst=1 for 2 cycles with all inputs nonzero (ex_wdata=32'hDEADBEEF, ex_whilo=1) -> every output 0; after release with stall=0, the next edge gives mem_wdata=32'hDEADBEEF, mem_valid=1.
- Bubble with accumulator: stall=6'b001000, hilo_i=64'h0000_0001_0000_0002, cnt_i=1, ex_wreg=1 -> mem_wreg=0, mem_valid=0, hilo_o=64'h0000_0001_0000_0002, cnt_o=1, bubble_cnt=1. Then stall=0 -> hilo_o=0, cnt_o=0, mem_* = ex_*.
- Hold: capture ex_wd=5'd7, ex_wdata=32'h1234; then stall=6'b011000 for 3 cycles with changed inputs -> mem_wd=7, mem_wdata=32'h1234 throughout; bubble_cnt unchanged.
- Flush priority: flush=1 with stall=6'b001000 and hilo_i nonzero -> all outputs 0 except bubble_cnt, which is unchanged.
- Saturation: preload via 65535 bubble cycles (BCNT_W=16), then 3 more bubble cycles -> bubble_cnt stays 16'hFFFF.
- Illegal stall: stall=6'b010000 -> outputs hold previous values; assertion reported.
